// File: rtl/ref_mem_pkg.sv
// Shared constants and types for the reference-memory read path.
// Tag layout and address wrap are used by every memory reader.
package ref_mem_pkg;

   localparam int DEPTH  = 96;
   localparam int ADDR_W = 7;
   localparam int ROWS   = 8;
   localparam int ROW_W  = 4;
   localparam int RD_LAT = 2;

   localparam logic [ROW_W-1:0] SEL_8ROW = '0;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_e;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [ROW_W-1:0]  row;
   } tag_t;

   function automatic logic [ADDR_W-1:0] addr_inc(
      input logic [ADDR_W-1:0] a
   );
      return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/ref_rd_ctrl_if.sv
// Command/status bundle between the read scheduler and its users.
// The slave side is the scheduler; the master side drives requests.
interface ref_rd_ctrl_if;
   import ref_mem_pkg::*;

   logic              start;
   logic              mode;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] len;
   logic              stall;
   logic              load_done;

   logic [ADDR_W-1:0] rd_address;
   logic              rd8R_en;
   logic [ROW_W-1:0]  rdR_sel;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [ROW_W-1:0]  out_row;
   logic              busy;
   logic              done;

   modport master (
      output start, mode, base_addr, len, stall, load_done,
      input  rd_address, rd8R_en, rdR_sel,
      input  out_valid, out_addr, out_row, busy, done
   );

   modport slave (
      input  start, mode, base_addr, len, stall, load_done,
      output rd_address, rd8R_en, rdR_sel,
      output out_valid, out_addr, out_row, busy, done
   );

endinterface

// File: rtl/ref_tag_pipe.sv
// Fixed-latency tag shift register; its tail lines up with the
// memory output so consumers know what each data beat is.
module ref_tag_pipe
   import ref_mem_pkg::*;
#(
   parameter int LAT = RD_LAT
) (
   input  logic clk,
   input  logic rst,
   input  tag_t push_i,
   output tag_t tail_o
);

   tag_t pipe_q [LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= push_i;
         for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign tail_o = pipe_q[LAT-1];

endmodule

// File: rtl/ref_rd_ctrl.sv
// Read scheduler for the banked reference memory: burst or per-row
// sweeps, with a tag stream aligned to the memory read latency.
module ref_rd_ctrl
   import ref_mem_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   ref_rd_ctrl_if.slave bus
);

   localparam int DRN_W = $clog2(RD_LAT + 1);

   state_e            state_q, state_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
   logic [ADDR_W-1:0] remain_q, remain_d;
   logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
   logic [DRN_W-1:0]  drain_q, drain_d;

   logic [ADDR_W-1:0] rd_address_q, rd_address_d;
   logic              rd_en_q, rd_en_d;
   logic [ROW_W-1:0]  rd_sel_q, rd_sel_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              row_wrap;
   logic              last_issue;

   tag_t              push;
   tag_t              tail;

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      addr_cnt_d   = addr_cnt_q;
      remain_d     = remain_q;
      row_cnt_d    = row_cnt_q;
      drain_d      = drain_q;
      rd_address_d = rd_address_q;
      rd_en_d      = 1'b0;
      rd_sel_d     = SEL_8ROW;
      done_d       = 1'b0;

      // A burst read finishes its word at once; a sweep only after row 8
      row_wrap   = !mode_q || (row_cnt_q == ROW_W'(ROWS));
      last_issue = row_wrap && (remain_q == ADDR_W'(1));

      unique case (state_q)
         IDLE: begin
            if (bus.start && bus.load_done) begin
               state_d    = ISSUE;
               mode_d     = bus.mode;
               addr_cnt_d = bus.base_addr;
               remain_d   = (bus.len == '0) ? ADDR_W'(1) : bus.len;
               row_cnt_d  = ROW_W'(1);
            end
         end
         ISSUE: begin
            if (!bus.stall) begin
               rd_en_d      = 1'b1;
               rd_address_d = addr_cnt_q;
               rd_sel_d     = mode_q ? row_cnt_q : SEL_8ROW;
               if (row_wrap) begin
                  addr_cnt_d = addr_inc(addr_cnt_q);
                  remain_d   = remain_q - ADDR_W'(1);
                  row_cnt_d  = ROW_W'(1);
               end else begin
                  row_cnt_d  = row_cnt_q + ROW_W'(1);
               end
               if (last_issue) begin
                  state_d = DRAIN;
                  drain_d = DRN_W'(RD_LAT - 1);
               end
            end
         end
         DRAIN: begin
            if (drain_q == '0) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q - DRN_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == ISSUE) || (state_d == DRAIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         mode_q       <= 1'b0;
         addr_cnt_q   <= '0;
         remain_q     <= '0;
         row_cnt_q    <= '0;
         drain_q      <= '0;
         rd_address_q <= '0;
         rd_en_q      <= 1'b0;
         rd_sel_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         addr_cnt_q   <= addr_cnt_d;
         remain_q     <= remain_d;
         row_cnt_q    <= row_cnt_d;
         drain_q      <= drain_d;
         rd_address_q <= rd_address_d;
         rd_en_q      <= rd_en_d;
         rd_sel_q     <= rd_sel_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Idle cycles push an all-zero tag so the output side reads clean
   assign push = rd_en_q
               ? tag_t'{valid: 1'b1, addr: rd_address_q, row: rd_sel_q}
               : tag_t'('0);

   ref_tag_pipe #(
      .LAT (RD_LAT)
   ) u_tag_pipe (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .tail_o (tail)
   );

   assign bus.rd_address = rd_address_q;
   assign bus.rd8R_en    = rd_en_q;
   assign bus.rdR_sel    = rd_sel_q;
   assign bus.out_valid  = tail.valid;
   assign bus.out_addr   = tail.addr;
   assign bus.out_row    = tail.row;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule
